// File: rtl/exec_sequencer.sv
// Execute-stage sequencer: decodes one RV32 ALU/JALR/LUI instruction at a time,
// finishes simple ops in a cycle and runs shifts iteratively through a one-entry output register.
module exec_sequencer #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        ADC_CLK_10,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pc_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] rs1_data_in,
  input  logic [31:0] rs2_data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_out,
  output logic [4:0]  rd_out,
  output logic        rd_we_out,
  output logic        jump_out,
  output logic [31:0] jump_target,
  output logic        illegal_out,
  output logic        busy
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  function automatic logic [31:0] shift_by(input logic [31:0] v, input logic [1:0] op,
                                           input logic [4:0] s);
    logic signed [31:0] vs;
    vs = v;
    case (op)
      SH_SLL:  shift_by = v << s;
      SH_SRA:  shift_by = vs >>> s;
      default: shift_by = v >> s;
    endcase
  endfunction

  logic [6:0]         opc;
  logic [2:0]         f3;
  logic [6:0]         f7;
  logic [4:0]         rd_f;
  logic [31:0]        imm_i;
  logic [31:0]        op2;
  logic signed [31:0] rs1_s;
  logic signed [31:0] op2_s;
  logic [4:0]         amt;
  logic               alu_ok;
  logic               unused;

  assign opc    = iw_in[6:0];
  assign f3     = iw_in[14:12];
  assign f7     = iw_in[31:25];
  assign rd_f   = iw_in[11:7];
  assign imm_i  = {{20{iw_in[31]}}, iw_in[31:20]};
  assign op2    = (opc == OP_R) ? rs2_data_in : imm_i;
  assign rs1_s  = rs1_data_in;
  assign op2_s  = op2;
  assign amt    = (opc == OP_R) ? rs2_data_in[4:0] : iw_in[24:20];
  assign alu_ok = (opc == OP_I) || (f7 == F7_BASE);
  assign unused = &{1'b0, iw_in[19:15]};

  logic        dec_legal;
  logic        dec_jump;
  logic        dec_shift;
  logic [31:0] dec_res;
  logic [31:0] dec_tgt;
  logic [1:0]  dec_shop;

  // Decode: I-type non-shift ops carry imm bits in func7, so only R-type checks it
  always_comb begin
    dec_legal = 1'b0;
    dec_jump  = 1'b0;
    dec_shift = 1'b0;
    dec_res   = '0;
    dec_tgt   = '0;
    dec_shop  = SH_SLL;
    case (opc)
      OP_R, OP_I: begin
        case (f3)
          3'b000: begin
            if (alu_ok) begin
              dec_legal = 1'b1;
              dec_res   = rs1_data_in + op2;
            end else if (f7 == F7_ALT) begin
              dec_legal = 1'b1;
              dec_res   = rs1_data_in - op2;
            end
          end
          3'b001: begin
            if (f7 == F7_BASE) begin
              dec_legal = 1'b1;
              dec_shift = 1'b1;
              dec_shop  = SH_SLL;
              dec_res   = rs1_data_in;
            end
          end
          3'b010: begin
            if (alu_ok) begin
              dec_legal = 1'b1;
              dec_res   = {31'b0, rs1_s < op2_s};
            end
          end
          3'b011: begin
            if (alu_ok) begin
              dec_legal = 1'b1;
              dec_res   = {31'b0, rs1_data_in < op2};
            end
          end
          3'b100: begin
            if (alu_ok) begin
              dec_legal = 1'b1;
              dec_res   = rs1_data_in ^ op2;
            end
          end
          3'b101: begin
            if (f7 == F7_BASE) begin
              dec_legal = 1'b1;
              dec_shift = 1'b1;
              dec_shop  = SH_SRL;
              dec_res   = rs1_data_in;
            end else if (f7 == F7_ALT) begin
              dec_legal = 1'b1;
              dec_shift = 1'b1;
              dec_shop  = SH_SRA;
              dec_res   = rs1_data_in;
            end
          end
          3'b110: begin
            if (alu_ok) begin
              dec_legal = 1'b1;
              dec_res   = rs1_data_in | op2;
            end
          end
          default: begin
            if (alu_ok) begin
              dec_legal = 1'b1;
              dec_res   = rs1_data_in & op2;
            end
          end
        endcase
      end
      OP_JALR: begin
        if (f3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_jump  = 1'b1;
          dec_res   = pc_in + 32'd4;
          dec_tgt   = (rs1_data_in + imm_i) & ~32'd1;
        end
      end
      OP_LUI: begin
        dec_legal = 1'b1;
        dec_res   = {iw_in[31:12], 12'b0};
      end
      default: ;
    endcase
  end

  logic [0:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [1:0]  shop_q, shop_d;
  logic [4:0]  rdl_q, rdl_d;
  logic        ov_q, ov_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  rdo_q, rdo_d;
  logic        we_q, we_d;
  logic        jmp_q, jmp_d;
  logic [31:0] tgt_q, tgt_d;
  logic        ill_q, ill_d;

  logic        accept;
  logic        drain;
  logic [4:0]  step;
  logic [4:0]  cnt_next;
  logic [31:0] shifted;

  assign in_ready = (state_q == ST_IDLE) && (!ov_q || out_ready) && !reset;
  assign accept   = in_valid && in_ready;
  assign drain    = ov_q && out_ready;
  assign step     = (cnt_q < STEP) ? cnt_q : STEP;
  assign cnt_next = cnt_q - step;
  assign shifted  = shift_by(acc_q, shop_q, step);

  // Sequencing: a shift is only started with the output register drained, so its
  // completion can always load without checking out_ready
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    shop_d  = shop_q;
    rdl_d   = rdl_q;
    ov_d    = ov_q;
    alu_d   = alu_q;
    rdo_d   = rdo_q;
    we_d    = we_q;
    jmp_d   = jmp_q;
    tgt_d   = tgt_q;
    ill_d   = ill_q;
    if (drain) ov_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (accept && dec_shift && (amt != 5'd0)) begin
        state_d = ST_SHIFT;
        cnt_d   = amt;
        acc_d   = rs1_data_in;
        shop_d  = dec_shop;
        rdl_d   = rd_f;
      end else if (accept) begin
        ov_d  = 1'b1;
        alu_d = dec_res;
        rdo_d = rd_f;
        we_d  = dec_legal && (rd_f != 5'd0);
        jmp_d = dec_jump;
        tgt_d = dec_tgt;
        ill_d = !dec_legal;
      end
    end else begin
      acc_d = shifted;
      cnt_d = cnt_next;
      if (cnt_next == 5'd0) begin
        state_d = ST_IDLE;
        ov_d    = 1'b1;
        alu_d   = shifted;
        rdo_d   = rdl_q;
        we_d    = (rdl_q != 5'd0);
        jmp_d   = 1'b0;
        tgt_d   = '0;
        ill_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge ADC_CLK_10) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      shop_q  <= SH_SLL;
      rdl_q   <= '0;
      ov_q    <= 1'b0;
      alu_q   <= '0;
      rdo_q   <= '0;
      we_q    <= 1'b0;
      jmp_q   <= 1'b0;
      tgt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      shop_q  <= shop_d;
      rdl_q   <= rdl_d;
      ov_q    <= ov_d;
      alu_q   <= alu_d;
      rdo_q   <= rdo_d;
      we_q    <= we_d;
      jmp_q   <= jmp_d;
      tgt_q   <= tgt_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid   = ov_q;
  assign alu_out     = alu_q;
  assign rd_out      = rdo_q;
  assign rd_we_out   = we_q;
  assign jump_out    = jmp_q;
  assign jump_target = tgt_q;
  assign illegal_out = ill_q;
  assign busy        = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: table of single-cycle ops plus shift, stall and reset sequences.
module tb_exec_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_valid4, out_ready;
  logic [31:0] pc_in, iw_in, rs1, rs2;

  logic        in_ready, out_valid, rd_we, jump, ill, busy;
  logic [31:0] alu, tgt;
  logic [4:0]  rd;
  logic        in_ready4, out_valid4, rd_we4, jump4, ill4, busy4;
  logic [31:0] alu4, tgt4;
  logic [4:0]  rd4;

  int n_cmp = 0;
  int n_bad = 0;

  exec_sequencer #(.SHIFT_STEP(1)) dut (
    .ADC_CLK_10(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .iw_in(iw_in), .rs1_data_in(rs1), .rs2_data_in(rs2),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu), .rd_out(rd),
    .rd_we_out(rd_we), .jump_out(jump), .jump_target(tgt), .illegal_out(ill), .busy(busy)
  );

  exec_sequencer #(.SHIFT_STEP(4)) dut4 (
    .ADC_CLK_10(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .pc_in(pc_in), .iw_in(iw_in), .rs1_data_in(rs1), .rs2_data_in(rs2),
    .out_valid(out_valid4), .out_ready(out_ready), .alu_out(alu4), .rd_out(rd4),
    .rd_we_out(rd_we4), .jump_out(jump4), .jump_target(tgt4), .illegal_out(ill4), .busy(busy4)
  );

  typedef struct {
    logic [31:0] iw;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic        jmp;
    logic [31:0] tgt;
    logic        ill;
    logic        chk_tgt;
  } vec_t;

  localparam int NV = 22;
  vec_t vt[NV];

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rdn);
    return {f7, 5'd2, 5'd1, f3, rdn, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rdn, input logic [6:0] op);
    return {imm, 5'd1, f3, rdn, op};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply_vec(input int i);
    string nm;
    nm = $sformatf("vec%0d", i);
    @(negedge clk);
    iw_in = vt[i].iw; pc_in = vt[i].pc; rs1 = vt[i].a; rs2 = vt[i].b;
    in_valid = 1'b1;
    #1;
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    if (i == 0) chk({nm, " out_valid before"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({nm, " out_valid"}, 32'(out_valid), 32'd1);
    chk({nm, " alu_out"}, alu, vt[i].res);
    chk({nm, " rd_out"}, 32'(rd), 32'(vt[i].rd));
    chk({nm, " rd_we"}, 32'(rd_we), 32'(vt[i].we));
    chk({nm, " jump"}, 32'(jump), 32'(vt[i].jmp));
    chk({nm, " illegal"}, 32'(ill), 32'(vt[i].ill));
    if (vt[i].chk_tgt) chk({nm, " target"}, tgt, vt[i].tgt);
  endtask

  task automatic run_shift(input string nm, input logic use4, input logic [31:0] iw,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                           input int exp_cyc, input logic [4:0] exp_rd);
    int cyc;
    @(negedge clk);
    iw_in = iw; rs1 = a; rs2 = b;
    if (use4) in_valid4 = 1'b1;
    else in_valid = 1'b1;
    #1;
    chk({nm, " in_ready"}, 32'(use4 ? in_ready4 : in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cyc = 0;
    while ((use4 ? busy4 : busy) && cyc < 40) begin
      chk({nm, " in_ready busy"}, 32'(use4 ? in_ready4 : in_ready), 32'd0);
      chk({nm, " out_valid busy"}, 32'(use4 ? out_valid4 : out_valid), 32'd0);
      cyc++;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_valid4 = 1'b0;
    chk({nm, " busy cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({nm, " out_valid"}, 32'(use4 ? out_valid4 : out_valid), 32'd1);
    chk({nm, " alu_out"}, use4 ? alu4 : alu, exp);
    chk({nm, " rd_out"}, 32'(use4 ? rd4 : rd), 32'(exp_rd));
    chk({nm, " rd_we"}, 32'(use4 ? rd_we4 : rd_we), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    vt[0]  = '{enc_r(7'h00, 3'b000, 5'd3), 32'h0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 5'd3, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[1]  = '{enc_r(7'h20, 3'b000, 5'd5), 32'h0, 32'h5, 32'h7, 32'hFFFFFFFE, 5'd5, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[2]  = '{enc_r(7'h00, 3'b010, 5'd6), 32'h0, 32'hFFFFFFFF, 32'h1, 32'h1, 5'd6, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[3]  = '{enc_r(7'h00, 3'b011, 5'd6), 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 5'd6, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[4]  = '{enc_r(7'h00, 3'b100, 5'd7), 32'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 5'd7, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[5]  = '{enc_r(7'h00, 3'b110, 5'd8), 32'h0, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 5'd8, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[6]  = '{enc_r(7'h00, 3'b111, 5'd9), 32'h0, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'h30303030, 5'd9, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[7]  = '{enc_i(12'hFFF, 3'b000, 5'd10, 7'b0010011), 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 5'd10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[8]  = '{enc_i(12'hFFF, 3'b011, 5'd11, 7'b0010011), 32'h0, 32'h5, 32'h0, 32'h1, 5'd11, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[9]  = '{enc_i(12'hFFF, 3'b010, 5'd11, 7'b0010011), 32'h0, 32'h5, 32'h0, 32'h0, 5'd11, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[10] = '{enc_i(12'h0FF, 3'b100, 5'd12, 7'b0010011), 32'h0, 32'h00000F0F, 32'h0, 32'h00000FF0, 5'd12, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[11] = '{enc_i(12'h800, 3'b110, 5'd12, 7'b0010011), 32'h0, 32'h1, 32'h0, 32'hFFFFF801, 5'd12, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[12] = '{enc_i(12'h7FF, 3'b111, 5'd12, 7'b0010011), 32'h0, 32'hFFFFFFFF, 32'h0, 32'h000007FF, 5'd12, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[13] = '{{20'hABCDE, 5'd13, 7'b0110111}, 32'h0, 32'h0, 32'h0, 32'hABCDE000, 5'd13, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[14] = '{enc_i(12'd4, 3'b000, 5'd1, 7'b1100111), 32'h100, 32'h2001, 32'h0, 32'h104, 5'd1, 1'b1, 1'b1, 32'h2004, 1'b0, 1'b1};
    vt[15] = '{enc_i(12'd4, 3'b000, 5'd0, 7'b1100111), 32'h100, 32'h2001, 32'h0, 32'h104, 5'd0, 1'b0, 1'b1, 32'h2004, 1'b0, 1'b1};
    vt[16] = '{enc_i(12'h0, 3'b010, 5'd4, 7'b0000011), 32'h0, 32'h1234, 32'h5, 32'h0, 5'd4, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
    vt[17] = '{enc_r(7'h01, 3'b000, 5'd3), 32'h0, 32'h1, 32'h1, 32'h0, 5'd3, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
    vt[18] = '{enc_r(7'h01, 3'b101, 5'd3), 32'h0, 32'h80, 32'h5, 32'h0, 5'd3, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
    vt[19] = '{enc_r(7'h00, 3'b001, 5'd14), 32'h0, 32'h1234, 32'h20, 32'h1234, 5'd14, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[20] = '{enc_r(7'h00, 3'b000, 5'd0), 32'h0, 32'h1, 32'h1, 32'h2, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[21] = '{enc_i({7'h20, 5'd0}, 3'b101, 5'd15, 7'b0010011), 32'h0, 32'h80000000, 32'h0, 32'h80000000, 5'd15, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};

    reset = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1;
    pc_in = '0; iw_in = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset alu_out", alu, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset illegal", 32'(ill), 32'd0);
    in_valid = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < NV; i++) apply_vec(i);

    run_shift("sra31 step1", 1'b0, enc_r(7'h20, 3'b101, 5'd7), 32'h80000000, 32'd31, 32'hFFFFFFFF, 31, 5'd7);
    run_shift("slli3 step1", 1'b0, enc_i({7'h00, 5'd3}, 3'b001, 5'd9, 7'b0010011), 32'h1, 32'h0, 32'h8, 3, 5'd9);
    run_shift("sra31 step4", 1'b1, enc_r(7'h20, 3'b101, 5'd7), 32'h80000000, 32'd31, 32'hFFFFFFFF, 8, 5'd7);
    run_shift("srl6 step4", 1'b1, enc_r(7'h00, 3'b101, 5'd10), 32'hF0000000, 32'd6, 32'h03C00000, 2, 5'd10);

    // Backpressure: first result held while XOR waits, then one result per cycle
    @(negedge clk);
    out_ready = 1'b0;
    iw_in = enc_r(7'h00, 3'b000, 5'd3); rs1 = 32'h1; rs2 = 32'h2;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iw_in = enc_r(7'h00, 3'b100, 5'd4); rs1 = 32'hFF; rs2 = 32'h0F;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall in_ready", 32'(in_ready), 32'd0);
      chk("stall out_valid", 32'(out_valid), 32'd1);
      chk("stall alu_out", alu, 32'h3);
      chk("stall rd_out", 32'(rd), 32'd3);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("b2b xor alu", alu, 32'hF0);
    chk("b2b xor rd", 32'(rd), 32'd4);
    chk("b2b xor valid", 32'(out_valid), 32'd1);
    iw_in = enc_r(7'h00, 3'b011, 5'd5); rs1 = 32'h1; rs2 = 32'h2;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b sltu alu", alu, 32'h1);
    chk("b2b sltu rd", 32'(rd), 32'd5);
    @(posedge clk);
    @(negedge clk);
    chk("b2b drained", 32'(out_valid), 32'd0);

    // Reset on the fifth shift edge of an SLL by 20
    iw_in = enc_r(7'h00, 3'b001, 5'd8); rs1 = 32'h1; rs2 = 32'd20;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset alu_out", alu, 32'd0);
    chk("midreset rd_out", 32'(rd), 32'd0);
    chk("midreset rd_we", 32'(rd_we), 32'd0);
    chk("midreset jump", 32'(jump), 32'd0);
    chk("midreset target", tgt, 32'd0);
    chk("midreset illegal", 32'(ill), 32'd0);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen = seen | out_valid | busy;
    end
    chk("midreset no output", 32'(seen), 32'd0);
    apply_vec(0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
